uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Controller that sequences the peripheral-bus UART.
- CPU-side byte writes are queued in a small FIFO and issued to the UART transmitter one at a time. Each byte gets a one-cycle start pulse, and the next byte waits for a full busy/idle cycle of the transmitter.
- Also holds received bytes in a single-entry register with valid/ack and a sticky overrun flag.
- Sits between the memory-mapped peripheral register file and the UART TX/RX cores.

Parameters:
- DEPTH, 8, TX FIFO entries; must be a power of 2, at least 2.
- AW, 3, log2(DEPTH); pointer width.
- TIMEOUT, 16, cycles allowed for tx_status to fall after tx_start (used only with the optional feature).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  CPU push strobe, one byte per cycle
- wr_data  in  8  byte to queue
- full  out  1  FIFO holds DEPTH entries
- empty  out  1  FIFO holds 0 entries
- count  out  AW+1  current FIFO occupancy, 0..DEPTH
- tx_overflow  out  1  sticky: a push was dropped while full
- tx_status  in  1  1 = UART transmitter idle, 0 = busy
- tx_data  out  8  byte presented to the transmitter
- tx_start  out  1  one-cycle send pulse
- tx_timeout  out  1  sticky watchdog flag (optional feature)
- rx_status  in  1  one-cycle pulse: new byte on rx_data_in
- rx_data_in  in  8  received byte
- rx_byte  out  8  held received byte
- rx_valid  out  1  rx_byte unread
- rx_ack  in  1  CPU has read rx_byte
- rx_overrun  out  1  sticky: unread byte was overwritten
- clr_flags  in  1  clears tx_overflow, tx_timeout and rx_overrun

Behaviour:
- Reset: async on reset low. Values:
  - FIFO pointers and count = 0; empty = 1, full = 0.
  - State = IDLE; tx_data = 8'h00; tx_start = 0.
  - rx_byte = 8'h00; all flags = 0.
  - A reset mid-transfer abandons the byte in flight and discards the queue.
- Push handling:
  - Push accepted when wr_en = 1 and full = 0.
  - Push with full = 1 is dropped, tx_overflow <= 1, even if a pop occurs in the same cycle.
  - Accepted push and pop in the same cycle: count unchanged, pointers both advance.
  - Pointers wrap modulo DEPTH.
- tx_start is decoded from state (state == START) and is high for exactly one cycle.
- FSM states:
  - IDLE: if empty = 0 and tx_status = 1 then tx_data <= FIFO head, pop, go to START. Otherwise stay.
  - START: tx_start = 1; go to WAIT_BUSY unconditionally.
  - WAIT_BUSY: stay until tx_status = 0, then go to WAIT_DONE.
  - WAIT_DONE: stay until tx_status = 1, then go to IDLE.
- Latency:
  - Push sampled at edge N into an empty FIFO with the transmitter idle: tx_data is valid after edge N+1, and tx_start is high during the cycle between edges N+1 and N+2.
  - Minimum spacing between consecutive tx_start pulses is 4 cycles.
- tx_data holds its value from load until the next load.
- RX handling:
  - When rx_status = 1: rx_byte <= rx_data_in, rx_valid <= 1.
  - If rx_valid was already 1 and rx_ack = 0 in that cycle, rx_overrun <= 1; the new byte still replaces the old one.
  - rx_ack = 1 with rx_status = 0 clears rx_valid.
  - rx_ack and rx_status in the same cycle: new byte stored, rx_valid stays 1, no overrun.
- Flags: clr_flags clears all sticky flags. A set event in the same cycle as clr_flags wins (flag = 1).
- count, full and empty are registered and update on the edge of the push/pop.

Optional Feature:
- Macro: UART_TX_TIMEOUT_EN.
- Defined: a counter runs in WAIT_BUSY.
  - If tx_status stays 1 for TIMEOUT cycles after entering WAIT_BUSY, the FSM returns to IDLE and tx_timeout <= 1. The byte is treated as sent, not retried.
  - The counter resets on entering WAIT_BUSY.
- Not defined: WAIT_BUSY waits indefinitely; tx_timeout is tied to 0; no counter logic.

Test Plan:
- Reset then push 8'hA5 with tx_status = 1 held: tx_data = 8'hA5 after edge N+1, tx_start exactly 1 cycle wide. The bench model drops tx_status for 10 cycles, then raises it; FSM returns to IDLE; empty = 1.
- Push 8'h01..8'h08 back-to-back while tx_status = 0: full = 1, count = 8. A ninth push of 8'h09 sets tx_overflow, and 8'h09 is never transmitted. Releasing the UART yields 01..08 in order.
- Push while the FSM pops in the same cycle, with count = 3: count stays 3, and byte order is preserved across the pointer wrap (push 12 bytes total).
- rx_status pulse with 8'h3C, then 8'h7E without ack: rx_byte = 8'h7E, rx_overrun = 1. A later rx_status together with rx_ack: no new overrun, rx_valid = 1. clr_flags then clears rx_overrun.
- Assert reset low during WAIT_DONE with 3 bytes queued: all outputs return to reset values asynchronously, and no further tx_start occurs after release.
- With UART_TX_TIMEOUT_EN, hold tx_status = 1 after tx_start: after 16 cycles the FSM is in IDLE, tx_timeout = 1, and the next queued byte starts. Without the macro, the FSM stays in WAIT_BUSY and tx_timeout = 0.

Source files
------------

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: queues CPU bytes in a FIFO, issues them to the transmitter one at a time,
// and holds received bytes with valid/ack. Optional transmit watchdog enabled by UART_TX_TIMEOUT_EN.

module uart_tx_sched #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count,
  output logic        tx_overflow,
  input  logic        tx_status,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        tx_timeout,
  input  logic        rx_status,
  input  logic [7:0]  rx_data_in,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  input  logic        rx_ack,
  output logic        rx_overrun,
  input  logic        clr_flags
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_tx_sched: DEPTH must be a power of 2 and at least 2");
  end
  if (AW != $clog2(DEPTH)) begin : g_bad_aw
    $error("uart_tx_sched: AW must equal log2(DEPTH)");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("uart_tx_sched: TIMEOUT must be at least 1");
  end

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_nxt;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          push;
  logic          pop;
  logic          overflow_evt;
  logic          overrun_evt;

  // A push against a full FIFO is dropped even if a pop frees a slot on the same edge.
  assign push         = wr_en && !full;
  assign overflow_evt = wr_en && full;
  assign pop          = (state == ST_IDLE) && !empty && tx_status;
  assign tx_start     = (state == ST_START);
  assign overrun_evt  = rx_status && rx_valid && !rx_ack;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

`ifdef UART_TX_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  logic [TW-1:0] to_cnt;
  logic          timeout_evt;
`endif

  always_comb begin
    state_nxt = state;
`ifdef UART_TX_TIMEOUT_EN
    timeout_evt = 1'b0;
`endif
    case (state)
      ST_IDLE:      if (pop) state_nxt = ST_START;
      ST_START:     state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!tx_status) begin
          state_nxt = ST_WAIT_DONE;
        end
`ifdef UART_TX_TIMEOUT_EN
        // Transmitter never went busy: treat the byte as sent and move on.
        else if (to_cnt == TO_LAST) begin
          state_nxt   = ST_IDLE;
          timeout_evt = 1'b1;
        end
`endif
      end
      ST_WAIT_DONE: if (tx_status) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      tx_data <= 8'h00;
    end else begin
      state <= state_nxt;
      if (pop) tx_data <= mem[rd_ptr];
    end
  end

`ifdef UART_TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt     <= '0;
      tx_timeout <= 1'b0;
    end else begin
      if (state == ST_START)          to_cnt <= '0;
      else if (state == ST_WAIT_BUSY) to_cnt <= to_cnt + TO_ONE;
      tx_timeout <= (tx_timeout && !clr_flags) || timeout_evt;
    end
  end
`else
  assign tx_timeout = 1'b0;
`endif

  // Sticky flags: a set event on the same edge as clr_flags wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_overflow <= 1'b0;
      rx_overrun  <= 1'b0;
    end else begin
      tx_overflow <= (tx_overflow && !clr_flags) || overflow_evt;
      rx_overrun  <= (rx_overrun && !clr_flags) || overrun_evt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
    end else if (rx_status) begin
      rx_byte  <= rx_data_in;
      rx_valid <= 1'b1;
    end else if (rx_ack) begin
      rx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: directed scenarios plus randomized traffic against a queue model
// of the byte stream, an emulated UART transmitter, and a single-entry RX holding model.

module tb_uart_tx_sched;

  localparam int DEPTH   = 8;
  localparam int AW      = 3;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        tx_overflow;
  logic        tx_status;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_timeout;
  logic        rx_status;
  logic [7:0]  rx_data_in;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ack;
  logic        rx_overrun;
  logic        clr_flags;

  always #5 clk = ~clk;

  uart_tx_sched #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .tx_overflow(tx_overflow),
    .tx_status  (tx_status),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_timeout (tx_timeout),
    .rx_status  (rx_status),
    .rx_data_in (rx_data_in),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .rx_overrun (rx_overrun),
    .clr_flags  (clr_flags)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: bytes accepted but not yet handed to the transmitter, plus flag expectations.
  logic [7:0] q[$];
  logic       exp_ovf, exp_to, exp_rv, exp_ro;
  logic [7:0] exp_rb, last_tx;
  int         cyc = 0;
  int         last_start = -100;
  int         starts = 0;
  int         idle_wait = 0;
  int         busy_left = 0;
  bit         live_chk = 0;
  bit         uart_auto = 0;

  task automatic model_reset();
    q.delete();
    exp_ovf = 0; exp_to = 0; exp_rv = 0; exp_ro = 0;
    exp_rb = 8'h00; last_tx = 8'h00;
    busy_left = 0; idle_wait = 0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_count"},   count, 0);
    check({pfx, "_empty"},   empty, 1);
    check({pfx, "_full"},    full, 0);
    check({pfx, "_txstart"}, tx_start, 0);
    check({pfx, "_txdata"},  tx_data, 8'h00);
    check({pfx, "_rxbyte"},  rx_byte, 8'h00);
    check({pfx, "_rxvalid"}, rx_valid, 0);
    check({pfx, "_flags"},   {tx_overflow, tx_timeout, rx_overrun}, 3'b000);
  endtask

  // One clock: inputs set before the call are sampled at the posedge; outputs are checked at the negedge.
  task automatic tick();
    int pre;
    logic st;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    pre = q.size();
    if (wr_en && pre < DEPTH) q.push_back(wr_data);
    exp_ovf = (exp_ovf && !clr_flags) || (wr_en && pre == DEPTH);
    exp_to  = exp_to && !clr_flags;
    exp_ro  = (exp_ro && !clr_flags) || (rx_status && exp_rv && !rx_ack);
    if (rx_status) begin
      exp_rb = rx_data_in;
      exp_rv = 1;
    end else if (rx_ack) begin
      exp_rv = 0;
    end
    st = tx_start;
    if (st) begin
      starts++;
      check("start_with_data", pre > 0, 1);
      if (pre > 0) begin
        last_tx = q.pop_front();
        check("tx_data_order", tx_data, last_tx);
      end
      check("start_spacing_ge4", (cyc - last_start) >= 4, 1);
      last_start = cyc;
    end else begin
      check("tx_data_hold", tx_data, last_tx);
    end
    check("count", count, q.size());
    check("full", full, q.size() == DEPTH);
    check("empty", empty, q.size() == 0);
    check("tx_overflow", tx_overflow, exp_ovf);
    check("tx_timeout", tx_timeout, exp_to);
    check("rx_byte", rx_byte, exp_rb);
    check("rx_valid", rx_valid, exp_rv);
    check("rx_overrun", rx_overrun, exp_ro);
    if (live_chk) begin
      if (tx_status && q.size() > 0 && !st) idle_wait++;
      else idle_wait = 0;
      if (idle_wait == 7) check("start_liveness_wait", idle_wait, 6);
    end
    wr_en = 0; rx_status = 0; rx_ack = 0; clr_flags = 0;
    // Emulated transmitter: busy for a few cycles after each start pulse.
    if (uart_auto) begin
      if (st) begin
        tx_status = 0;
        busy_left = $urandom_range(2, 7);
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_status = 1;
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en = 1;
    wr_data = b;
    tick();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((q.size() > 0 || busy_left > 0 || !tx_status) && n < 300) begin
      tick();
      n++;
    end
    tick();
    tick();
    check({tag, "_drained"}, q.size(), 0);
  endtask

  task automatic apply_reset(input string pfx);
    #2;
    reset = 0;
    #1;
    check_reset_vals(pfx);
    model_reset();
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t, expected < 500000", $time);
    $fatal(1);
  end

  initial begin
    int s0, pushed, bound, p_push;
    reset = 1; wr_en = 0; wr_data = 8'h00; tx_status = 1;
    rx_status = 0; rx_data_in = 8'h00; rx_ack = 0; clr_flags = 0;
    model_reset();
    #1 reset = 0;
    @(negedge clk);
    check_reset_vals("por");
    reset = 1;

    // Single byte: latency and pulse width.
    tx_status = 1;
    push_byte(8'hA5);
    check("a5_no_start_at_n", tx_start, 0);
    tick();
    check("a5_start_n1", tx_start, 1);
    check("a5_data_n1", tx_data, 8'hA5);
    tx_status = 0;
    tick();
    check("a5_start_width", tx_start, 0);
    repeat (9) tick();
    tx_status = 1;
    repeat (3) tick();
    check("a5_empty_after", empty, 1);

    // Fill while the transmitter is busy, overflow, then release.
    tx_status = 0;
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    check("fill_full", full, 1);
    check("fill_count", count, 8);
    push_byte(8'h09);
    check("fill_overflow", tx_overflow, 1);
    s0 = starts;
    uart_auto = 1; live_chk = 1; busy_left = 0; tx_status = 1;
    drain("fill");
    check("fill_sent_8", starts - s0, 8);
    clr_flags = 1;
    tick();

    // Push coinciding with pop at count 3, across the pointer wrap.
    uart_auto = 0; live_chk = 0; tx_status = 0;
    for (int i = 0; i < 3; i++) push_byte(8'h30 + 8'(i));
    uart_auto = 1; live_chk = 1; busy_left = 0; tx_status = 1;
    push_byte(8'h33);
    check("simul_start", tx_start, 1);
    check("simul_count", count, 3);
    pushed = 4;
    bound = 0;
    while (pushed < 12 && bound < 200) begin
      if (q.size() < DEPTH) begin
        wr_en = 1;
        wr_data = 8'h30 + 8'(pushed);
        pushed++;
      end
      tick();
      bound++;
    end
    check("wrap_pushed", pushed, 12);
    drain("wrap");

    // RX holding register.
    rx_status = 1; rx_data_in = 8'h3C;
    tick();
    check("rx_first_valid", rx_valid, 1);
    rx_status = 1; rx_data_in = 8'h7E;
    tick();
    check("rx_overwrite_byte", rx_byte, 8'h7E);
    check("rx_overwrite_ovr", rx_overrun, 1);
    clr_flags = 1;
    tick();
    check("rx_clr", rx_overrun, 0);
    rx_status = 1; rx_ack = 1; rx_data_in = 8'h5A;
    tick();
    check("rx_ack_same_valid", rx_valid, 1);
    check("rx_ack_same_noovr", rx_overrun, 0);
    rx_status = 1; clr_flags = 1; rx_data_in = 8'hC3;
    tick();
    check("rx_set_beats_clr", rx_overrun, 1);
    clr_flags = 1;
    tick();
    rx_ack = 1;
    tick();
    check("rx_ack_clears", rx_valid, 0);

    // Reset in WAIT_DONE with three bytes queued.
    uart_auto = 0; live_chk = 0; tx_status = 1;
    for (int i = 0; i < 4; i++) begin
      push_byte(8'hD0 + 8'(i));
      if (tx_start) tx_status = 0;
    end
    tick();
    check("rst_pre_count", count, 3);
    apply_reset("midrst");
    tx_status = 1;
    s0 = starts;
    repeat (20) tick();
    check("rst_no_start_after", starts - s0, 0);

    // Transmitter that never reports busy.
    push_byte(8'h61);
    push_byte(8'h62);
    check("to_first_start", tx_start, 1);
    s0 = starts;
`ifdef UART_TX_TIMEOUT_EN
    repeat (16) tick();
    check("to_not_yet", tx_timeout, 0);
    exp_to = 1;
    tick();
    check("to_flag", tx_timeout, 1);
    tick();
    check("to_next_start", tx_start, 1);
    check("to_next_data", tx_data, 8'h62);
    uart_auto = 1; tx_status = 0; busy_left = 2;
`else
    repeat (30) tick();
    check("to_stuck_no_start", starts - s0, 0);
    check("to_stuck_count", count, 1);
    check("to_flag_tied", tx_timeout, 0);
    uart_auto = 1; tx_status = 0; busy_left = 2;
`endif
    drain("to");
    clr_flags = 1;
    tick();

    // Randomized traffic at several push densities.
    uart_auto = 1; live_chk = 1;
    for (int seg = 0; seg < 4; seg++) begin
      p_push = (seg == 0) ? 20 : (seg == 1) ? 50 : (seg == 2) ? 90 : 100;
      for (int i = 0; i < 200; i++) begin
        wr_en      = ($urandom_range(0, 99) < p_push);
        wr_data    = 8'($urandom);
        rx_status  = ($urandom_range(0, 99) < 25);
        rx_data_in = 8'($urandom);
        rx_ack     = ($urandom_range(0, 99) < 25);
        clr_flags  = ($urandom_range(0, 99) < 4);
        tick();
      end
    end
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
